sram_like_responder: RTL and testbench
======================================

// Module: sram_like_responder
// PURPOSE
//   Memory-side responder for the pipeline's instruction-fetch and data-access ports.
//   Serves both ports over an SRAM-like req/addr_ok/data_ok handshake from one
//   single-ported word RAM with a programmable response latency.
//   Sits between the CPU top (pcF/instrF, aluoutM/writedataM/readdataM) and the
//   backing store. Gives the hazard unit realistic multi-cycle memory timing.
// PARAMETERS
//   DEPTH_LOG2  10  log2 of RAM depth in 32-bit words
//   LATENCY     1   cycles from accept edge to data_ok; legal 1..15
// PORTS
//   clk            in   1   clock, all state on rising edge
//   rst            in   1   reset, asynchronous, active-low
//   inst_req       in   1   fetch request
//   inst_addr      in   32  fetch byte address
//   inst_addr_ok   out  1   fetch request accepted this cycle
//   inst_data_ok   out  1   fetch data valid (one-cycle pulse)
//   inst_rdata     out  32  fetched word
//   data_req       in   1   load/store request
//   data_wr        in   1   1 = store, 0 = load
//   data_size      in   2   0 = byte, 1 = half, 2 = word (3 treated as word)
//   data_addr      in   32  load/store byte address
//   data_wdata     in   32  store data, right-aligned
//   data_addr_ok   out  1   data request accepted this cycle
//   data_data_ok   out  1   load data valid / store done (one-cycle pulse)
//   data_rdata     out  32  loaded word
// BEHAVIOUR
//   - Reset (rst=0, async): state IDLE, counter 0, all *_ok = 0, both rdata = 0.
//     RAM contents are not reset.
//   - FSM states: IDLE, BUSY, RESP.
//     - IDLE: addr_ok is combinational. data_addr_ok = data_req.
//       inst_addr_ok = inst_req & ~data_req, so data has fixed priority.
//     - Accept = req & addr_ok at a clock edge. That edge latches source, addr, wr,
//       size and wdata, and enters BUSY (LATENCY>1) or RESP (LATENCY=1).
//     - BUSY: counter runs 1..LATENCY-1, then moves to RESP. Both addr_ok outputs are 0.
//     - RESP: the selected *_data_ok = 1 for exactly one cycle, then the FSM returns
//       to IDLE. addr_ok = 0 in RESP.
//   - Latency and throughput:
//     - Accept at edge t gives data_ok high in the cycle after edge t+LATENCY-1.
//     - Back-to-back throughput is one transaction per LATENCY+1 cycles.
//   - Addressing: word index = addr[DEPTH_LOG2+1:2], wrapping modulo 2^DEPTH_LOG2.
//   - Reads:
//     - Return the full word regardless of size or addr[1:0].
//     - rdata is registered at the edge entering RESP and held until the next
//       response on that port. The other port's rdata is unchanged.
//   - Stores: little-endian byte lanes.
//     - size 0: wdata[7:0] written to lane addr[1:0].
//     - size 1: wdata[15:0] written to lanes {addr[1],0}+1..0.
//     - size 2: all four lanes.
//     - The RAM write commits at the edge entering RESP.
//   - Simultaneous data_req & inst_req in IDLE: data accepted; inst stays pending and
//     the CPU must hold it.
//   - A request that drops before acceptance is ignored.
//   - Reset mid-transaction aborts it: no data_ok is issued, and an uncommitted store
//     is discarded.
//   - Misaligned half/word addresses: low address bits ignored (aligned down).
// CONFIGURATION
//   SRAM_RESP_ERR_EN defined:
//     - Adds output ports inst_err and data_err (1 bit each), pulsed together with
//       the matching data_ok.
//     - err = 1 when addr[31:DEPTH_LOG2+2] != 0, or when a half access has addr[0]=1,
//       or a word access has addr[1:0]!=0.
//     - On err, stores are suppressed and rdata is forced to 32'h0.
//   SRAM_RESP_ERR_EN undefined:
//     - No err ports.
//     - Out-of-range addresses wrap and misalignment is ignored, as in BEHAVIOUR.
// TESTING
//   - Reset: hold rst=0 with both reqs=1 -> all *_ok=0 and rdata=0. Release -> data
//     accepted first.
//   - LATENCY=3: store word 32'hDEADBEEF at 0x10, then load 0x10 -> data_data_ok exactly
//     3 cycles after each accept; data_rdata=32'hDEADBEEF.
//   - Byte/half stores to a word holding 32'h00000000:
//     - Store byte 8'hAA at 0x21, then half 16'h1234 at 0x22.
//     - Word load at 0x20 -> 32'h1234AA00.
//   - Contention: inst_req and data_req both high in IDLE -> data_addr_ok=1,
//     inst_addr_ok=0. inst is accepted in the IDLE cycle after data_data_ok.
//     inst_rdata stays unchanged during the data transaction.
//   - Abort: store accepted, rst pulsed low during BUSY -> no data_ok. Later load of
//     that address returns the old value.
//   - ERR_EN, DEPTH_LOG2=10:
//     - Load at 0x00001000 -> data_err=1 with data_ok, data_rdata=0.
//     - Word store at 0x2 -> err=1 and memory unchanged.

Source files
------------

// File: rtl/sram_like_responder.sv
// sram_like_responder
//   Memory-side responder for the instruction-fetch and data-access ports of
//   the pipeline. Both ports share one single-ported word RAM and speak an
//   SRAM-like req / addr_ok / data_ok handshake with a programmable response
//   latency.
//
// Parameters
//   DEPTH_LOG2  log2 of RAM depth in 32-bit words
//   LATENCY     cycles from the accept edge to data_ok (1..15)
//
// Ports
//   clk           clock, all state on the rising edge
//   rst           asynchronous reset, active low
//   inst_req      fetch request
//   inst_addr     fetch byte address
//   inst_addr_ok  fetch request accepted this cycle (combinational in IDLE)
//   inst_data_ok  fetch data valid, one-cycle pulse
//   inst_rdata    fetched word, held until the next fetch response
//   data_req      load/store request
//   data_wr       1 = store, 0 = load
//   data_size     0 = byte, 1 = half, 2/3 = word
//   data_addr     load/store byte address
//   data_wdata    store data, right-aligned
//   data_addr_ok  data request accepted this cycle (combinational in IDLE)
//   data_data_ok  load data valid / store done, one-cycle pulse
//   data_rdata    loaded word, held until the next data response
//   inst_err      (SRAM_RESP_ERR_EN only) fetch error, pulsed with inst_data_ok
//   data_err      (SRAM_RESP_ERR_EN only) data error, pulsed with data_data_ok
//
// Optional feature
//   SRAM_RESP_ERR_EN  adds the err ports; out-of-range or misaligned accesses
//                     return zero and suppress stores. Without it, addresses
//                     wrap and low address bits are ignored.
module sram_like_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata
`ifdef SRAM_RESP_ERR_EN
  ,
  output logic        inst_err,
  output logic        data_err
`endif
);

  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0] LAST_CNT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        srcData_q;
  logic [31:0] addr_q;
  logic        wr_q;
  logic [1:0]  size_q;
  logic [31:0] wdata_q;
  logic        instDataOk_q;
  logic        dataDataOk_q;
  logic [31:0] instRdata_q;
  logic [31:0] dataRdata_q;
  logic        instErr_q;
  logic        dataErr_q;

  logic [31:0] mem [DEPTH];

  logic                  anyReq;
  logic                  enterResp;
  logic                  curData;
  logic [31:0]           curAddr;
  logic                  curWr;
  logic [1:0]            curSize;
  logic [31:0]           curWdata;
  logic [DEPTH_LOG2-1:0] curIdx;
  logic                  curErr;
  logic [3:0]            byteEn;
  logic [31:0]           laneData;
  logic                  doWrite;

  // Requests are only visible while idle and out of reset; data always wins.
  assign anyReq       = data_req | inst_req;
  assign data_addr_ok = rst & (state_q == IDLE) & data_req;
  assign inst_addr_ok = rst & (state_q == IDLE) & inst_req & ~data_req;

  assign inst_data_ok = instDataOk_q;
  assign data_data_ok = dataDataOk_q;
  assign inst_rdata   = instRdata_q;
  assign data_rdata   = dataRdata_q;
`ifdef SRAM_RESP_ERR_EN
  assign inst_err     = instErr_q;
  assign data_err     = dataErr_q;
`endif

  // With LATENCY=1 the accept edge is also the edge entering RESP, so the RAM
  // operation must see the live request rather than the latched copy.
  always_comb begin
    curData  = srcData_q;
    curAddr  = addr_q;
    curWr    = wr_q;
    curSize  = size_q;
    curWdata = wdata_q;
    if (state_q == IDLE) begin
      curData  = data_req;
      curAddr  = data_req ? data_addr : inst_addr;
      curWr    = data_req & data_wr;
      curSize  = data_req ? data_size : 2'd2;
      curWdata = data_wdata;
    end
  end

  assign enterResp = rst & (((state_q == IDLE) & anyReq & (LATENCY == 1)) |
                            ((state_q == BUSY) & (cnt_q == LAST_CNT)));

  assign curIdx = curAddr[DEPTH_LOG2+1:2];

`ifdef SRAM_RESP_ERR_EN
  // Fetches are word accesses, so a misaligned fetch address is an error too.
  assign curErr = (|curAddr[31:DEPTH_LOG2+2]) |
                  ((curSize == 2'd1) & curAddr[0]) |
                  (curSize[1] & (|curAddr[1:0]));
`else
  logic unused_hiAddr;
  assign unused_hiAddr = ^curAddr[31:DEPTH_LOG2+2];
  assign curErr        = 1'b0;
`endif

  // Little-endian lane selection; narrow data is replicated across lanes so
  // the byte enables alone pick the destination.
  always_comb begin
    byteEn   = 4'b1111;
    laneData = curWdata;
    case (curSize)
      2'd0: begin
        byteEn   = 4'b0001 << curAddr[1:0];
        laneData = {4{curWdata[7:0]}};
      end
      2'd1: begin
        byteEn   = curAddr[1] ? 4'b1100 : 4'b0011;
        laneData = {2{curWdata[15:0]}};
      end
      default: begin
        byteEn   = 4'b1111;
        laneData = curWdata;
      end
    endcase
  end

  assign doWrite = enterResp & curData & curWr & ~curErr;

  // RAM contents survive reset; stores commit only on the edge entering RESP,
  // so an aborted transaction never reaches the array.
  always_ff @(posedge clk) begin
    if (doWrite) begin
      for (int i = 0; i < 4; i++) begin
        if (byteEn[i]) begin
          mem[curIdx][8*i +: 8] <= laneData[8*i +: 8];
        end
      end
    end
  end

  // Control FSM with registered response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      srcData_q    <= 1'b0;
      addr_q       <= 32'h0;
      wr_q         <= 1'b0;
      size_q       <= 2'd0;
      wdata_q      <= 32'h0;
      instDataOk_q <= 1'b0;
      dataDataOk_q <= 1'b0;
      instRdata_q  <= 32'h0;
      dataRdata_q  <= 32'h0;
      instErr_q    <= 1'b0;
      dataErr_q    <= 1'b0;
    end else begin
      instDataOk_q <= 1'b0;
      dataDataOk_q <= 1'b0;
      instErr_q    <= 1'b0;
      dataErr_q    <= 1'b0;

      case (state_q)
        IDLE: begin
          if (anyReq) begin
            srcData_q <= curData;
            addr_q    <= curAddr;
            wr_q      <= curWr;
            size_q    <= curSize;
            wdata_q   <= curWdata;
            cnt_q     <= 4'd1;
            state_q   <= (LATENCY == 1) ? RESP : BUSY;
          end
        end
        BUSY: begin
          if (cnt_q == LAST_CNT) begin
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        RESP: begin
          state_q <= IDLE;
          cnt_q   <= 4'd0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase

      // Stores keep the previous read data unless flagged as an error.
      if (enterResp) begin
        if (curData) begin
          dataDataOk_q <= 1'b1;
          dataErr_q    <= curErr;
          if (curErr) begin
            dataRdata_q <= 32'h0;
          end else if (!curWr) begin
            dataRdata_q <= mem[curIdx];
          end
        end else begin
          instDataOk_q <= 1'b1;
          instErr_q    <= curErr;
          instRdata_q  <= curErr ? 32'h0 : mem[curIdx];
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_like_responder.sv
// tb_sram_like_responder
//   Directed bench for sram_like_responder with LATENCY=3, DEPTH_LOG2=10.
//   Inputs change on the falling edge and outputs are sampled there too.
module tb_sram_like_responder;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
`ifdef SRAM_RESP_ERR_EN
  logic        inst_err;
  logic        data_err;
`endif

  int total = 0;
  int bad = 0;
  int cycleCount = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount++;

  sram_like_responder #(
    .DEPTH_LOG2(10),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .inst_req(inst_req),
    .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata),
    .data_req(data_req),
    .data_wr(data_wr),
    .data_size(data_size),
    .data_addr(data_addr),
    .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .data_rdata(data_rdata)
`ifdef SRAM_RESP_ERR_EN
    ,
    .inst_err(inst_err),
    .data_err(data_err)
`endif
  );

  // Issues one data transaction and waits (bounded) for its data_ok.
  task automatic doData(input logic wr, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rd,
                        output logic aok, output int acc, output logic err);
    @(negedge clk);
    data_req   = 1'b1;
    data_wr    = wr;
    data_size  = size;
    data_addr  = addr;
    data_wdata = wdata;
    #1 aok = data_addr_ok;
    @(negedge clk);
    acc = cycleCount;
    data_req = 1'b0;
    lat = 1;
    err = 1'b0;
    while (data_data_ok !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = data_rdata;
`ifdef SRAM_RESP_ERR_EN
    err = data_err;
`endif
  endtask

  // Issues one fetch and waits (bounded) for its data_ok.
  task automatic doInst(input logic [31:0] addr, output int lat,
                        output logic [31:0] rd, output logic aok);
    @(negedge clk);
    inst_req  = 1'b1;
    inst_addr = addr;
    #1 aok = inst_addr_ok;
    @(negedge clk);
    inst_req = 1'b0;
    lat = 1;
    while (inst_data_ok !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = inst_rdata;
  endtask

  task automatic test_reset();
    int waitCnt;
    rst = 1'b0;
    data_req = 1'b1;
    inst_req = 1'b1;
    data_wr = 1'b0;
    data_size = 2'd2;
    data_addr = 32'h40;
    inst_addr = 32'h44;
    repeat (3) @(negedge clk);
    #1;
    total++; if (data_addr_ok !== 1'b0) begin bad++; $display("[TB] FAIL reset_data_addr_ok got=%b want=0", data_addr_ok); end
    total++; if (inst_addr_ok !== 1'b0) begin bad++; $display("[TB] FAIL reset_inst_addr_ok got=%b want=0", inst_addr_ok); end
    total++; if (data_data_ok !== 1'b0) begin bad++; $display("[TB] FAIL reset_data_data_ok got=%b want=0", data_data_ok); end
    total++; if (inst_data_ok !== 1'b0) begin bad++; $display("[TB] FAIL reset_inst_data_ok got=%b want=0", inst_data_ok); end
    total++; if (data_rdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_data_rdata got=%h want=0", data_rdata); end
    total++; if (inst_rdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_inst_rdata got=%h want=0", inst_rdata); end
    rst = 1'b1;
    #1;
    total++; if (data_addr_ok !== 1'b1) begin bad++; $display("[TB] FAIL release_data_first got=%b want=1", data_addr_ok); end
    total++; if (inst_addr_ok !== 1'b0) begin bad++; $display("[TB] FAIL release_inst_blocked got=%b want=0", inst_addr_ok); end
    @(negedge clk);
    data_req = 1'b0;
    inst_req = 1'b0;
    waitCnt = 1;
    while (data_data_ok !== 1'b1 && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    total++; if (waitCnt != LAT) begin bad++; $display("[TB] FAIL release_first_latency got=%0d want=%0d", waitCnt, LAT); end
  endtask

  task automatic test_latency();
    int lat, acc;
    logic [31:0] rd;
    logic aok, err;
    doData(1'b1, 2'd2, 32'h10, 32'hDEADBEEF, lat, rd, aok, acc, err);
    total++; if (aok !== 1'b1) begin bad++; $display("[TB] FAIL store_addr_ok got=%b want=1", aok); end
    total++; if (lat != LAT) begin bad++; $display("[TB] FAIL store_latency got=%0d want=%0d", lat, LAT); end
    doData(1'b0, 2'd2, 32'h10, 32'h0, lat, rd, aok, acc, err);
    total++; if (lat != LAT) begin bad++; $display("[TB] FAIL load_latency got=%0d want=%0d", lat, LAT); end
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL load_rdata got=%h want=deadbeef", rd); end
  endtask

  task automatic test_byte_half();
    int lat, acc;
    logic [31:0] rd;
    logic aok, err;
    doData(1'b1, 2'd2, 32'h20, 32'h00000000, lat, rd, aok, acc, err);
    doData(1'b1, 2'd0, 32'h21, 32'hFFFFFFAA, lat, rd, aok, acc, err);
    doData(1'b1, 2'd1, 32'h22, 32'hFFFF1234, lat, rd, aok, acc, err);
    doData(1'b0, 2'd2, 32'h20, 32'h0, lat, rd, aok, acc, err);
    total++; if (rd !== 32'h1234AA00) begin bad++; $display("[TB] FAIL byte_half_merge got=%h want=1234aa00", rd); end
    doData(1'b0, 2'd0, 32'h23, 32'h0, lat, rd, aok, acc, err);
    total++; if (rd !== 32'h1234AA00) begin bad++; $display("[TB] FAIL byte_load_full_word got=%h want=1234aa00", rd); end
  endtask

`ifndef SRAM_RESP_ERR_EN
  task automatic test_wrap_align();
    int lat, acc;
    logic [31:0] rd;
    logic aok, err;
    doData(1'b0, 2'd2, 32'h00001010, 32'h0, lat, rd, aok, acc, err);
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL addr_wrap got=%h want=deadbeef", rd); end
    doData(1'b1, 2'd2, 32'h32, 32'h11223344, lat, rd, aok, acc, err);
    doData(1'b0, 2'd2, 32'h30, 32'h0, lat, rd, aok, acc, err);
    total++; if (rd !== 32'h11223344) begin bad++; $display("[TB] FAIL word_align_down got=%h want=11223344", rd); end
    doData(1'b1, 2'd2, 32'h34, 32'h00000000, lat, rd, aok, acc, err);
    doData(1'b1, 2'd1, 32'h35, 32'h0000BEEF, lat, rd, aok, acc, err);
    doData(1'b0, 2'd2, 32'h34, 32'h0, lat, rd, aok, acc, err);
    total++; if (rd !== 32'h0000BEEF) begin bad++; $display("[TB] FAIL half_align_down got=%h want=0000beef", rd); end
  endtask
`endif

  task automatic test_contention();
    int lat;
    logic [31:0] rd;
    logic aok;
    int instChanged;
    int instOkEarly;
    doInst(32'h10, lat, rd, aok);
    total++; if (lat != LAT) begin bad++; $display("[TB] FAIL fetch_latency got=%0d want=%0d", lat, LAT); end
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL fetch_rdata got=%h want=deadbeef", rd); end
    @(negedge clk);
    data_req = 1'b1;
    data_wr = 1'b0;
    data_size = 2'd2;
    data_addr = 32'h20;
    inst_req = 1'b1;
    inst_addr = 32'h20;
    #1;
    total++; if (data_addr_ok !== 1'b1) begin bad++; $display("[TB] FAIL contend_data_ok got=%b want=1", data_addr_ok); end
    total++; if (inst_addr_ok !== 1'b0) begin bad++; $display("[TB] FAIL contend_inst_ok got=%b want=0", inst_addr_ok); end
    @(negedge clk);
    data_req = 1'b0;
    lat = 1;
    instChanged = 0;
    instOkEarly = 0;
    if (inst_rdata !== 32'hDEADBEEF) instChanged++;
    if (inst_addr_ok !== 1'b0) instOkEarly++;
    while (data_data_ok !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
      if (inst_rdata !== 32'hDEADBEEF) instChanged++;
      if (inst_addr_ok !== 1'b0) instOkEarly++;
    end
    total++; if (lat != LAT) begin bad++; $display("[TB] FAIL contend_data_latency got=%0d want=%0d", lat, LAT); end
    total++; if (data_rdata !== 32'h1234AA00) begin bad++; $display("[TB] FAIL contend_data_rdata got=%h want=1234aa00", data_rdata); end
    total++; if (instChanged != 0) begin bad++; $display("[TB] FAIL contend_inst_rdata_held got=%0d changes want=0", instChanged); end
    total++; if (instOkEarly != 0) begin bad++; $display("[TB] FAIL contend_inst_ok_while_busy got=%0d cycles want=0", instOkEarly); end
    @(negedge clk);
    #1;
    total++; if (inst_addr_ok !== 1'b1) begin bad++; $display("[TB] FAIL contend_inst_accept_after got=%b want=1", inst_addr_ok); end
    @(negedge clk);
    inst_req = 1'b0;
    lat = 1;
    while (inst_data_ok !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    total++; if (lat != LAT) begin bad++; $display("[TB] FAIL contend_inst_latency got=%0d want=%0d", lat, LAT); end
    total++; if (inst_rdata !== 32'h1234AA00) begin bad++; $display("[TB] FAIL contend_inst_rdata got=%h want=1234aa00", inst_rdata); end
  endtask

  task automatic test_abort();
    int lat, acc;
    logic [31:0] rd;
    logic aok, err;
    int okSeen;
    @(negedge clk);
    data_req = 1'b1;
    data_wr = 1'b1;
    data_size = 2'd2;
    data_addr = 32'h20;
    data_wdata = 32'h55555555;
    @(negedge clk);
    data_req = 1'b0;
    #1 rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    total++; if (data_rdata !== 32'h0) begin bad++; $display("[TB] FAIL abort_rdata_cleared got=%h want=0", data_rdata); end
    okSeen = 0;
    repeat (6) begin
      @(negedge clk);
      if (data_data_ok !== 1'b0) okSeen++;
    end
    total++; if (okSeen != 0) begin bad++; $display("[TB] FAIL abort_no_data_ok got=%0d pulses want=0", okSeen); end
    doData(1'b0, 2'd2, 32'h20, 32'h0, lat, rd, aok, acc, err);
    total++; if (rd !== 32'h1234AA00) begin bad++; $display("[TB] FAIL abort_store_discarded got=%h want=1234aa00", rd); end
  endtask

  task automatic test_back_to_back();
    int lat, acc1, acc2;
    logic [31:0] rd;
    logic aok, err;
    doData(1'b0, 2'd2, 32'h10, 32'h0, lat, rd, aok, acc1, err);
    doData(1'b0, 2'd2, 32'h20, 32'h0, lat, rd, aok, acc2, err);
    total++; if ((acc2 - acc1) != LAT + 1) begin bad++; $display("[TB] FAIL b2b_period got=%0d want=%0d", acc2 - acc1, LAT + 1); end
    total++; if (rd !== 32'h1234AA00) begin bad++; $display("[TB] FAIL b2b_second_rdata got=%h want=1234aa00", rd); end
  endtask

`ifdef SRAM_RESP_ERR_EN
  task automatic test_err();
    int lat, acc;
    logic [31:0] rd;
    logic aok, err;
    doData(1'b0, 2'd2, 32'h00001000, 32'h0, lat, rd, aok, acc, err);
    total++; if (err !== 1'b1) begin bad++; $display("[TB] FAIL err_range_flag got=%b want=1", err); end
    total++; if (rd !== 32'h0) begin bad++; $display("[TB] FAIL err_range_rdata got=%h want=0", rd); end
    doData(1'b1, 2'd2, 32'h0, 32'hCAFEF00D, lat, rd, aok, acc, err);
    doData(1'b1, 2'd2, 32'h2, 32'h99999999, lat, rd, aok, acc, err);
    total++; if (err !== 1'b1) begin bad++; $display("[TB] FAIL err_misalign_flag got=%b want=1", err); end
    doData(1'b0, 2'd2, 32'h0, 32'h0, lat, rd, aok, acc, err);
    total++; if (rd !== 32'hCAFEF00D) begin bad++; $display("[TB] FAIL err_store_suppressed got=%h want=cafef00d", rd); end
    total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL err_clean_flag got=%b want=0", err); end
  endtask
`endif

  initial begin
    rst = 1'b0;
    inst_req = 1'b0;
    inst_addr = 32'h0;
    data_req = 1'b0;
    data_wr = 1'b0;
    data_size = 2'd2;
    data_addr = 32'h0;
    data_wdata = 32'h0;
    test_reset();
    test_latency();
    test_byte_half();
`ifndef SRAM_RESP_ERR_EN
    test_wrap_align();
`endif
    test_contention();
    test_abort();
    test_back_to_back();
`ifdef SRAM_RESP_ERR_EN
    test_err();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
